rms_estimator: RTL and testbench

Computes a running RMS level of the Q1.15 audio stream and presents it, together with the matching sample, to the downstream noise gate. The block squares each incoming sample, folds it into a power estimate with a one-pole leaky integrator, and takes a bit-serial integer square root. Its outputs `x_out` and `rms_out` feed the gate's `x_in` and `rms_in` directly; both change on the same cycle, so sample and level stay aligned.

---
 rtl/rms_estimator_if.sv | 31 +++
 rtl/rms_estimator.sv | 140 ++++++++++++++
 tb/tb_rms_estimator.sv | 259 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rms_estimator_if.sv
// Sample stream between the upstream audio source, the RMS estimator and the
// downstream noise gate. The estimator consumes x_in and produces the aligned
// pair x_out / rms_out together with a one-cycle out_valid pulse.
interface rms_estimator_if;
    logic               in_valid;
    logic signed [15:0] x_in;
    logic               in_ready;
    logic               out_valid;
    logic signed [15:0] x_out;
    logic        [15:0] rms_out;

    // Estimator side
    modport slave (
        input  in_valid,
        input  x_in,
        output in_ready,
        output out_valid,
        output x_out,
        output rms_out
    );

    // Source / gate side
    modport master (
        output in_valid,
        output x_in,
        input  in_ready,
        input  out_valid,
        input  x_out,
        input  rms_out
    );
endinterface

// File: rtl/rms_estimator.sv
// Running RMS estimator for a Q1.15 audio stream.
// Each accepted sample is squared (Q2.30), folded into a one-pole leaky
// integrator p += (sq - p) >>> ALPHA_SHIFT, and then a 16-cycle restoring
// square root produces floor(sqrt(p)), which is already Q1.15. The sample
// and its level are published together on a single out_valid pulse.
module rms_estimator #(
    parameter int ALPHA_SHIFT = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    rms_estimator_if.slave bus
);

    typedef enum logic [1:0] {IDLE, UPDATE, SQRT, DONE} state_t;

    state_t state, state_nx;

    logic signed [15:0] xs;        // accepted sample
    logic        [30:0] p;         // power estimate, Q2.30, always < 2^30
    logic        [31:0] rad;       // radicand, consumed two bits per cycle
    logic        [17:0] rem;       // partial remainder, bounded by 2*r
    logic        [15:0] r;         // partial root
    logic        [3:0]  cnt;       // root bit counter

    logic               out_valid_q;
    logic signed [15:0] x_out_q;
    logic        [15:0] rms_out_q;

    logic        [30:0] sq;
    logic signed [32:0] d;
    logic        [30:0] p_upd;
    logic        [19:0] rem_sh;
    logic        [19:0] trial;
    logic        [17:0] rem_nx;
    logic        [15:0] root_nx;

    // Clamp to the largest positive Q1.15 value; only a guard, since p < 2^30
    // keeps the root at or below 32767.
    function automatic logic [15:0] sat_q15(input logic [15:0] v);
        return (v > 16'd32767) ? 16'd32767 : v;
    endfunction

    // Square and leaky-integrator update; floor shift keeps 0 <= p < 2^30.
    always_comb begin
        sq    = 31'(xs * xs);
        d     = $signed({2'b00, sq}) - $signed({2'b00, p});
        p_upd = 31'($signed({2'b00, p}) + (d >>> ALPHA_SHIFT));
    end

    // One restoring square-root step: try setting the next root bit.
    always_comb begin
        rem_sh = {rem, rad[31:30]};
        trial  = {2'b00, r, 2'b01};
        rem_nx = rem_sh[17:0];
        root_nx = {r[14:0], 1'b0};
        if (rem_sh >= trial) begin
            rem_nx  = 18'(rem_sh - trial);
            root_nx = {r[14:0], 1'b1};
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode; clr always returns to IDLE.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = UPDATE;
            UPDATE:  state_nx = SQRT;
            SQRT:    if (cnt == 4'd15) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clr) begin
            state_nx = IDLE;
        end
    end

    // Datapath: capture, integrate, iterate the root, publish the result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xs          <= '0;
            p           <= '0;
            rad         <= '0;
            rem         <= '0;
            r           <= '0;
            cnt         <= '0;
            out_valid_q <= 1'b0;
            x_out_q     <= '0;
            rms_out_q   <= '0;
        end else begin
            out_valid_q <= 1'b0;
            if (clr) begin
                p <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (bus.in_valid) begin
                            xs <= bus.x_in;
                        end
                    end
                    UPDATE: begin
                        p   <= p_upd;
                        rad <= {1'b0, p_upd};
                        rem <= '0;
                        r   <= '0;
                        cnt <= '0;
                    end
                    SQRT: begin
                        rad <= {rad[29:0], 2'b00};
                        rem <= rem_nx;
                        r   <= root_nx;
                        cnt <= cnt + 4'd1;
                        if (cnt == 4'd15) begin
                            rms_out_q   <= sat_q15(root_nx);
                            x_out_q     <= xs;
                            out_valid_q <= 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    assign bus.in_ready  = (state == IDLE);
    assign bus.out_valid = out_valid_q;
    assign bus.x_out     = x_out_q;
    assign bus.rms_out   = rms_out_q;

endmodule

// File: tb/tb_rms_estimator.sv
// Bench for rms_estimator: two instances (ALPHA_SHIFT = 8 and 1) share one
// stimulus stream; a transaction-level model predicts readiness, the output
// pulse and the published level using plain integer arithmetic.
module tb_rms_estimator;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               rst_n;
    logic               clr;
    logic               vld;
    logic signed [15:0] xin;

    rms_estimator_if bus8();
    rms_estimator_if bus1();

    assign bus8.in_valid = vld;
    assign bus8.x_in     = xin;
    assign bus1.in_valid = vld;
    assign bus1.x_in     = xin;

    rms_estimator #(.ALPHA_SHIFT(8)) dut8 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus8.slave));
    rms_estimator #(.ALPHA_SHIFT(1)) dut1 (.clk(clk), .rst_n(rst_n), .clr(clr), .bus(bus1.slave));

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic longint leak(input longint pw, input longint x, input int sh);
        longint dd;
        dd = x * x - pw;
        return pw + (dd >>> sh);
    endfunction

    function automatic longint isqrt(input longint v);
        longint rr;
        longint t;
        rr = 0;
        for (int b = 15; b >= 0; b--) begin
            t = rr | (longint'(1) << b);
            if (t * t <= v) rr = t;
        end
        return rr;
    endfunction

    function automatic longint sat(input longint v);
        return (v > 32767) ? 32767 : v;
    endfunction

    int     m_cnt  = 0;     // cycles until ready again; 0 = ready
    bit     m_ov   = 0;
    longint m_p8   = 0;
    longint m_p1   = 0;
    longint m_xs   = 0;
    longint exp_x  = 0;
    longint exp_r8 = 0;
    longint exp_r1 = 0;

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                m_cnt = 0; m_ov = 0; m_p8 = 0; m_p1 = 0; m_xs = 0;
                exp_x = 0; exp_r8 = 0; exp_r1 = 0;
            end else begin
                m_ov = 0;
                if (clr) begin
                    m_cnt = 0; m_p8 = 0; m_p1 = 0;
                end else if (m_cnt == 0) begin
                    if (vld) begin
                        m_cnt = 18;
                        m_xs  = xin;
                        m_p8  = leak(m_p8, m_xs, 8);
                        m_p1  = leak(m_p1, m_xs, 1);
                    end
                end else begin
                    m_cnt--;
                    if (m_cnt == 1) begin
                        m_ov   = 1;
                        exp_x  = m_xs;
                        exp_r8 = sat(isqrt(m_p8));
                        exp_r1 = sat(isqrt(m_p1));
                    end
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    bit          chk_en = 0;
    bit          mono8 = 0, mono1u = 0, mono1d = 0;
    bit          seen8 = 0, seen1u = 0, seen1d = 0;
    logic [15:0] prev8 = 0, prev1 = 0;
    int          ov_cnt8 = 0;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && chk_en) begin
                chk("in_ready8",  bus8.in_ready,  longint'(m_cnt == 0));
                chk("in_ready1",  bus1.in_ready,  longint'(m_cnt == 0));
                chk("out_valid8", bus8.out_valid, longint'(m_ov));
                chk("out_valid1", bus1.out_valid, longint'(m_ov));
                chk("x_out8",     bus8.x_out,     exp_x);
                chk("x_out1",     bus1.x_out,     exp_x);
                chk("rms8",       bus8.rms_out,   exp_r8);
                chk("rms1",       bus1.rms_out,   exp_r1);
                if (!mono8)  seen8  = 0;
                if (!mono1u) seen1u = 0;
                if (!mono1d) seen1d = 0;
                if (bus8.out_valid) begin
                    ov_cnt8++;
                    if (seen8) chk("mono_up8", longint'(bus8.rms_out >= prev8), 1);
                    prev8 = bus8.rms_out;
                    seen8 = mono8;
                end
                if (bus1.out_valid) begin
                    if (seen1u) chk("mono_up1", longint'(bus1.rms_out >= prev1), 1);
                    if (seen1d) chk("mono_dn1", longint'(bus1.rms_out <= prev1), 1);
                    prev1  = bus1.rms_out;
                    seen1u = mono1u;
                    seen1d = mono1d;
                end
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic single(input logic signed [15:0] x, output int lat);
        vld = 1; xin = x; lat = 0;
        @(negedge clk);
        vld = 0; lat = 1;
        while (!bus8.out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic stream(input logic signed [15:0] x, input int n);
        vld = 1; xin = x;
        repeat (n * 19) @(negedge clk);
        vld = 0;
    endtask

    initial begin
        int lat;
        int c0;
        rst_n = 0; clr = 0; vld = 0; xin = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1;
        chk_en = 1;
        #1;
        chk("rst_in_ready",  bus8.in_ready,  1);
        chk("rst_out_valid", bus8.out_valid, 0);
        chk("rst_rms",       bus8.rms_out,   0);
        chk("rst_x_out",     bus8.x_out,     0);
        @(negedge clk);

        // Single sample from p = 0
        single(16'sd16384, lat);
        chk("single_latency", lat, 18);
        chk("single_rms8",    bus8.rms_out, 1024);
        chk("single_rms1",    bus1.rms_out, 11585);
        chk("single_x_out",   bus8.x_out, 16384);
        chk("model_pin_r8",   exp_r8, 1024);
        chk("model_pin_p8",   m_p8, 1 << 20);
        @(negedge clk);
        chk("single_pulse_len", bus8.out_valid, 0);
        repeat (3) @(negedge clk);

        // clr beats in_valid in IDLE
        clr = 1; vld = 1; xin = 16'sd16384;
        @(negedge clk);
        clr = 0; vld = 0;
        c0 = ov_cnt8;
        repeat (22) @(negedge clk);
        chk("clr_prio_no_ov", ov_cnt8 - c0, 0);
        single(16'sd16384, lat);
        chk("clr_prio_rms8", bus8.rms_out, 1024);
        chk("clr_prio_rms1", bus1.rms_out, 11585);
        repeat (3) @(negedge clk);

        // clr during SQRT
        c0 = ov_cnt8;
        vld = 1; xin = 16'sd8192;
        @(negedge clk);
        vld = 0;
        repeat (8) @(negedge clk);
        clr = 1;
        @(negedge clk);
        clr = 0;
        repeat (25) @(negedge clk);
        chk("clr_mid_no_ov", ov_cnt8 - c0, 0);
        chk("clr_mid_rms8_hold", bus8.rms_out, 1024);
        chk("clr_mid_x_hold",    bus8.x_out, 16384);

        // Asynchronous reset during SQRT
        vld = 1; xin = 16'sd16384;
        @(negedge clk);
        vld = 0;
        repeat (6) @(negedge clk);
        #2 rst_n = 0;
        #1;
        chk("async_rst_rms8",  bus8.rms_out, 0);
        chk("async_rst_rms1",  bus1.rms_out, 0);
        chk("async_rst_x",     bus8.x_out, 0);
        chk("async_rst_ov",    bus8.out_valid, 0);
        @(negedge clk);
        rst_n = 1;
        #1;
        chk("rel_in_ready", bus8.in_ready, 1);
        c0 = ov_cnt8;
        repeat (25) @(negedge clk);
        chk("rst_no_ov", ov_cnt8 - c0, 0);

        // Convergence at ALPHA_SHIFT = 8, one accept per 19 cycles
        c0 = ov_cnt8;
        mono8 = 1;
        stream(16'sd16384, 2600);
        mono8 = 0;
        chk("conv_count", ov_cnt8 - c0, 2600);
        chk("conv_final", longint'(bus8.rms_out == 16'd16383 || bus8.rms_out == 16'd16384), 1);

        // Full scale at ALPHA_SHIFT = 1, then decay
        mono1u = 1;
        stream(-16'sd32768, 40);
        mono1u = 0;
        chk("fullscale_rms1", bus1.rms_out, 32767);
        chk("fullscale_x",    bus1.x_out, -32768);
        mono1d = 1;
        stream(16'sd0, 45);
        mono1d = 0;
        chk("decay_rms1", bus1.rms_out, 0);

        // Randomised traffic with occasional clr
        repeat (3000) begin
            vld = ($urandom_range(0, 9) < 7);
            xin = 16'($urandom);
            clr = ($urandom_range(0, 59) == 0);
            @(negedge clk);
        end
        vld = 0; clr = 0;
        repeat (25) @(negedge clk);

        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
